// File: rtl/io_ctrl_if.sv
// CPU bus, UART TX/RX handshakes and status flags of io_ctrl, grouped into one interface.
// master = CPU/UART environment side, slave = io_ctrl side.
interface io_ctrl_if;
  logic [31:0] cpu_a_in;
  logic [7:0]  cpu_dout_in;
  logic        cpu_wr_in;
  logic [7:0]  cpu_din_out;
  logic        io_buffer_full;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        rx_pop_out;
  logic        program_stop_out;
  logic        tx_overflow_out;

  modport master (
    output cpu_a_in, cpu_dout_in, cpu_wr_in, tx_ready_in, rx_data_in, rx_valid_in,
    input  cpu_din_out, io_buffer_full, tx_data_out, tx_valid_out, rx_pop_out,
           program_stop_out, tx_overflow_out
  );

  modport slave (
    input  cpu_a_in, cpu_dout_in, cpu_wr_in, tx_ready_in, rx_data_in, rx_valid_in,
    output cpu_din_out, io_buffer_full, tx_data_out, tx_valid_out, rx_pop_out,
           program_stop_out, tx_overflow_out
  );
endinterface

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped I/O block with UART TX FIFO, stop/drain sequencing and RX read port.
// Optional cycle counter + snapshot registers are built when IO_CTRL_CYCLE_COUNTER_EN is defined.
module io_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic     clk_in,
  input  logic     rst_in,
  io_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH - FULL_MARGIN);

  localparam logic [17:0] ADDR_DATA = 18'h30000;
  localparam logic [17:0] ADDR_CNT0 = 18'h30004;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_STOPPED} state_t;

  state_t          state_q, state_d;
  logic            pending_q, pending_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, overflow_q, overflow_set;
  logic [7:0]      din_q, rd_data;
  logic            rx_pop_q, rx_take;
  logic            push, pop, has_room, tx_valid;
  logic [7:0]      push_data;

  logic [17:0]     addr;
  logic            io_sel, io_wr, io_rd;
  logic            unused_addr_hi;

  assign addr           = bus.cpu_a_in[17:0];
  assign unused_addr_hi = ^bus.cpu_a_in[31:18];
  assign io_sel         = (addr[17:16] == 2'b11);
  assign io_wr          = io_sel && bus.cpu_wr_in;
  assign io_rd          = io_sel && !bus.cpu_wr_in;

  assign tx_valid = (count_q != '0);
  assign pop      = tx_valid && bus.tx_ready_in;
  // A pop on the same edge frees the slot, so a full FIFO can still accept a push.
  assign has_room = (count_q != DEPTH_CNT) || pop;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    push         = 1'b0;
    push_data    = bus.cpu_dout_in;
    overflow_set = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (io_wr && addr == ADDR_DATA && bus.cpu_dout_in != 8'h00) begin
          push         = has_room;
          overflow_set = !has_room;
        end else if (io_wr && addr == ADDR_CNT0) begin
          state_d   = ST_DRAIN;
          push_data = 8'h00;
          push      = has_room;
          pending_d = !has_room;
        end
      end
      ST_DRAIN: begin
        push_data = 8'h00;
        if (pending_q) begin
          push      = has_room;
          pending_d = !has_room;
        end else if (count_q == '0) begin
          state_d = ST_STOPPED;
        end
      end
      ST_STOPPED: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

`ifdef IO_CTRL_CYCLE_COUNTER_EN
  localparam logic [17:0] ADDR_CNT1 = 18'h30005;
  localparam logic [17:0] ADDR_CNT2 = 18'h30006;
  localparam logic [17:0] ADDR_CNT3 = 18'h30007;

  logic [31:0] cycle_q, snap_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_q <= '0;
      snap_q  <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (io_rd && addr == ADDR_CNT0) snap_q <= cycle_q;
    end
  end
`endif

  always_comb begin
    rd_data = 8'h00;
    rx_take = 1'b0;
    case (addr)
      ADDR_DATA: begin
        rx_take = bus.rx_valid_in;
        rd_data = bus.rx_valid_in ? bus.rx_data_in : 8'h00;
      end
`ifdef IO_CTRL_CYCLE_COUNTER_EN
      ADDR_CNT0: rd_data = cycle_q[7:0];
      ADDR_CNT1: rd_data = snap_q[15:8];
      ADDR_CNT2: rd_data = snap_q[23:16];
      ADDR_CNT3: rd_data = snap_q[31:24];
`endif
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_RUN;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      din_q      <= 8'h00;
      rx_pop_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      full_q   <= (count_d >= FULL_LEVEL);
      if (overflow_set) overflow_q <= 1'b1;
      if (io_rd) din_q <= rd_data;
      rx_pop_q <= io_rd && rx_take;
    end
  end

  // NOTE: the storage array is not reset; count gates visibility, so stale entries are never presented.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign bus.cpu_din_out      = din_q;
  assign bus.io_buffer_full   = full_q;
  assign bus.tx_valid_out     = tx_valid;
  assign bus.tx_data_out      = tx_valid ? mem[rd_ptr_q] : 8'h00;
  assign bus.rx_pop_out       = rx_pop_q;
  assign bus.program_stop_out = (state_q == ST_STOPPED);
  assign bus.tx_overflow_out  = overflow_q;
endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_io_ctrl;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;
  localparam logic [17:0] A_DATA = 18'h30000;
  localparam logic [17:0] A_CNT0 = 18'h30004;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_STOP  = 2;
`ifdef IO_CTRL_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  io_ctrl_if bus();

  io_ctrl #(.FIFO_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO as a queue, bytes the model expects on the TX line, bytes actually seen.
  logic [7:0]  m_fifo[$];
  logic [7:0]  m_tx[$];
  logic [7:0]  seen_q[$];
  int          m_mode;
  bit          m_pending;
  bit          m_overflow;
  logic [31:0] m_cycles;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) m_cycles <= '0;
    else         m_cycles <= m_cycles + 32'd1;
  end

  function automatic logic [31:0] io_addr(input logic [17:0] off);
    logic [13:0] hi;
    hi = 14'($urandom());
    return {hi, off};
  endfunction

  function automatic logic [31:0] nonio_addr();
    logic [31:0] a;
    a = $urandom();
    a[17:16] = 2'($urandom_range(0, 2));
    return a;
  endfunction

  function automatic void model_clear();
    m_fifo.delete();
    m_tx.delete();
    seen_q.delete();
    m_mode     = M_RUN;
    m_pending  = 1'b0;
    m_overflow = 1'b0;
  endfunction

  function automatic void model_edge(input logic wr, input logic [31:0] a, input logic [7:0] d,
                                     input logic rdy);
    bit io_wr;
    bit done;
    io_wr = (a[17:16] == 2'b11) && (wr === 1'b1);
    done  = (m_mode == M_DRAIN) && (m_fifo.size() == 0) && !m_pending;
    if (rdy === 1'b1 && m_fifo.size() != 0) m_tx.push_back(m_fifo.pop_front());
    if (m_mode == M_RUN && io_wr && a[17:0] == A_DATA && d != 8'h00) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
      else                       m_overflow = 1'b1;
    end else if (m_mode == M_RUN && io_wr && a[17:0] == A_CNT0) begin
      m_mode = M_DRAIN;
      if (m_fifo.size() < DEPTH) m_fifo.push_back(8'h00);
      else                       m_pending = 1'b1;
    end else if (m_mode == M_DRAIN && m_pending && m_fifo.size() < DEPTH) begin
      m_fifo.push_back(8'h00);
      m_pending = 1'b0;
    end
    if (done) m_mode = M_STOP;
  endfunction

  // One bus cycle: drive at the falling edge, clock, return at the next falling edge to sample.
  task automatic cycle(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus.cpu_wr_in   = wr;
    bus.cpu_a_in    = a;
    bus.cpu_dout_in = d;
    if (bus.tx_valid_out === 1'b1 && bus.tx_ready_in === 1'b1) seen_q.push_back(bus.tx_data_out);
    model_edge(wr, a, d, bus.tx_ready_in);
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0000_0000, 8'h00);
  endtask

  task automatic do_reset();
    rst_in          = 1'b0;
    bus.cpu_wr_in   = 1'b0;
    bus.cpu_a_in    = '0;
    bus.cpu_dout_in = '0;
    bus.tx_ready_in = 1'b0;
    bus.rx_valid_in = 1'b0;
    bus.rx_data_in  = '0;
    repeat (2) @(negedge clk_in);
    model_clear();
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_in          = 1'b0;
    bus.cpu_wr_in   = 1'b0;
    bus.cpu_a_in    = io_addr(A_DATA);
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = 8'hC3;
    bus.tx_ready_in = 1'b1;
    repeat (3) @(negedge clk_in);
    n_cmp++; if (bus.cpu_din_out !== 8'h00) begin n_bad++; $display("FAIL reset_din: got %h want 00", bus.cpu_din_out); end
    n_cmp++; if (bus.io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.io_buffer_full); end
    n_cmp++; if (bus.tx_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid_out); end
    n_cmp++; if (bus.tx_data_out !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data_out); end
    n_cmp++; if (bus.rx_pop_out !== 1'b0) begin n_bad++; $display("FAIL reset_rx_pop: got %b want 0", bus.rx_pop_out); end
    n_cmp++; if (bus.program_stop_out !== 1'b0) begin n_bad++; $display("FAIL reset_stop: got %b want 0", bus.program_stop_out); end
    n_cmp++; if (bus.tx_overflow_out !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", bus.tx_overflow_out); end
  endtask

  task automatic test_zero_filter();
    do_reset();
    bus.tx_ready_in = 1'b1;
    cycle(1'b1, io_addr(A_DATA), 8'h41);
    n_cmp++; if (bus.tx_data_out !== 8'h41 || bus.tx_valid_out !== 1'b1) begin n_bad++; $display("FAIL zf_first: got v=%b d=%h want v=1 d=41", bus.tx_valid_out, bus.tx_data_out); end
    cycle(1'b1, io_addr(A_DATA), 8'h00);
    n_cmp++; if (bus.tx_valid_out !== 1'b0) begin n_bad++; $display("FAIL zf_zero_dropped: got v=%b want 0", bus.tx_valid_out); end
    cycle(1'b1, io_addr(A_DATA), 8'h42);
    n_cmp++; if (bus.tx_data_out !== 8'h42 || bus.tx_valid_out !== 1'b1) begin n_bad++; $display("FAIL zf_second: got v=%b d=%h want v=1 d=42", bus.tx_valid_out, bus.tx_data_out); end
    idle(4);
    n_cmp++;
    if (seen_q.size() != 2) begin
      n_bad++; $display("FAIL zf_count: got %0d bytes want 2", seen_q.size());
    end else if (seen_q[0] !== 8'h41 || seen_q[1] !== 8'h42) begin
      n_bad++; $display("FAIL zf_stream: got %h %h want 41 42", seen_q[0], seen_q[1]);
    end
  endtask

  task automatic test_rx_read();
    logic [7:0] exp_din;
    logic       exp_pop;
    do_reset();
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = 8'h7A;
    cycle(1'b0, io_addr(A_DATA), 8'h00);
    n_cmp++; if (bus.cpu_din_out !== 8'h7A) begin n_bad++; $display("FAIL rx_data: got %h want 7a", bus.cpu_din_out); end
    n_cmp++; if (bus.rx_pop_out !== 1'b1) begin n_bad++; $display("FAIL rx_pop: got %b want 1", bus.rx_pop_out); end
    idle(1);
    n_cmp++; if (bus.rx_pop_out !== 1'b0) begin n_bad++; $display("FAIL rx_pop_single: got %b want 0", bus.rx_pop_out); end
    bus.rx_valid_in = 1'b0;
    bus.rx_data_in  = 8'h55;
    cycle(1'b0, io_addr(A_DATA), 8'h00);
    n_cmp++; if (bus.cpu_din_out !== 8'h00) begin n_bad++; $display("FAIL rx_empty_data: got %h want 00", bus.cpu_din_out); end
    n_cmp++; if (bus.rx_pop_out !== 1'b0) begin n_bad++; $display("FAIL rx_empty_pop: got %b want 0", bus.rx_pop_out); end
    for (int i = 0; i < 6; i++) begin
      bus.rx_valid_in = 1'($urandom_range(0, 1));
      bus.rx_data_in  = 8'($urandom());
      exp_din = bus.rx_valid_in ? bus.rx_data_in : 8'h00;
      exp_pop = bus.rx_valid_in;
      cycle(1'b0, io_addr(A_DATA), 8'h00);
      n_cmp++; if (bus.cpu_din_out !== exp_din || bus.rx_pop_out !== exp_pop) begin
        n_bad++; $display("FAIL rx_rand: got d=%h p=%b want d=%h p=%b", bus.cpu_din_out, bus.rx_pop_out, exp_din, exp_pop);
      end
    end
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = 8'h99;
    cycle(1'b0, nonio_addr(), 8'h00);
    n_cmp++; if (bus.rx_pop_out !== 1'b0) begin n_bad++; $display("FAIL rx_nonio_pop: got %b want 0", bus.rx_pop_out); end
    bus.rx_valid_in = 1'b0;
  endtask

  task automatic test_counter();
    logic [31:0] snap;
    logic [7:0]  exp;
    int          budget;
    do_reset();
    snap = m_cycles;
    cycle(1'b0, io_addr(A_CNT0), 8'h00);
    exp = CNT_EN ? snap[7:0] : 8'h00;
    n_cmp++; if (bus.cpu_din_out !== exp) begin n_bad++; $display("FAIL cnt_first: got %h want %h", bus.cpu_din_out, exp); end
    budget = 0;
    while (m_cycles != 32'h0000_01FF && budget < 1000) begin
      idle(1);
      budget++;
    end
    n_cmp++; if (m_cycles !== 32'h0000_01FF) begin n_bad++; $display("FAIL cnt_wait: got %h want 000001ff", m_cycles); end
    snap = m_cycles;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, io_addr(A_CNT0 + 18'(k)), 8'h00);
      exp = CNT_EN ? snap[k*8 +: 8] : 8'h00;
      n_cmp++; if (bus.cpu_din_out !== exp) begin n_bad++; $display("FAIL cnt_byte%0d: got %h want %h", k, bus.cpu_din_out, exp); end
    end
    idle($urandom_range(1, 40));
    snap = m_cycles;
    cycle(1'b0, io_addr(A_CNT0), 8'h00);
    idle($urandom_range(300, 400));
    for (int k = 1; k < 4; k++) begin
      cycle(1'b0, io_addr(A_CNT0 + 18'(k)), 8'h00);
      exp = CNT_EN ? snap[k*8 +: 8] : 8'h00;
      n_cmp++; if (bus.cpu_din_out !== exp) begin n_bad++; $display("FAIL cnt_snap_hold%0d: got %h want %h", k, bus.cpu_din_out, exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] wrote[$];
    logic [7:0] d;
    int         budget;
    do_reset();
    bus.tx_ready_in = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      d = 8'($urandom_range(1, 255));
      if (i <= DEPTH) wrote.push_back(d);
      cycle(1'b1, io_addr(A_DATA), d);
      n_cmp++; if (bus.io_buffer_full !== (i >= DEPTH - MARGIN)) begin n_bad++; $display("FAIL bp_full_%0d: got %b", i, bus.io_buffer_full); end
      n_cmp++; if (bus.tx_overflow_out !== (i > DEPTH)) begin n_bad++; $display("FAIL bp_overflow_%0d: got %b", i, bus.tx_overflow_out); end
    end
    bus.tx_ready_in = 1'b1;
    d = 8'h99;
    wrote.push_back(d);
    cycle(1'b1, io_addr(A_DATA), d);
    n_cmp++; if (bus.io_buffer_full !== 1'b1) begin n_bad++; $display("FAIL bp_push_pop_full: got %b want 1", bus.io_buffer_full); end
    budget = 0;
    while (bus.tx_valid_out === 1'b1 && budget < 40) begin
      idle(1);
      budget++;
    end
    n_cmp++; if (bus.tx_valid_out !== 1'b0) begin n_bad++; $display("FAIL bp_drain_timeout: got v=%b want 0", bus.tx_valid_out); end
    n_cmp++;
    if (seen_q.size() != wrote.size()) begin
      n_bad++; $display("FAIL bp_count: got %0d bytes want %0d", seen_q.size(), wrote.size());
    end else begin
      for (int i = 0; i < wrote.size(); i++)
        if (seen_q[i] !== wrote[i]) begin n_bad++; $display("FAIL bp_byte%0d: got %h want %h", i, seen_q[i], wrote[i]); end
    end
    n_cmp++; if (bus.tx_overflow_out !== 1'b1 || bus.io_buffer_full !== 1'b0) begin
      n_bad++; $display("FAIL bp_after: got ovf=%b full=%b want ovf=1 full=0", bus.tx_overflow_out, bus.io_buffer_full);
    end
  endtask

  task automatic test_stop_pending();
    logic [7:0] wrote[$];
    logic [7:0] d;
    int         budget;
    do_reset();
    bus.tx_ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom_range(1, 255));
      wrote.push_back(d);
      cycle(1'b1, io_addr(A_DATA), d);
    end
    cycle(1'b1, io_addr(A_CNT0), 8'h77);
    wrote.push_back(8'h00);
    idle(3);
    n_cmp++; if (bus.tx_overflow_out !== 1'b0) begin n_bad++; $display("FAIL pend_overflow: got %b want 0", bus.tx_overflow_out); end
    n_cmp++; if (bus.program_stop_out !== 1'b0) begin n_bad++; $display("FAIL pend_stop_early: got %b want 0", bus.program_stop_out); end
    bus.tx_ready_in = 1'b1;
    budget = 0;
    while (bus.program_stop_out !== 1'b1 && budget < 60) begin
      cycle(1'b1, io_addr(A_DATA), 8'h3E);
      budget++;
    end
    n_cmp++; if (bus.program_stop_out !== 1'b1) begin n_bad++; $display("FAIL pend_stop: got %b want 1", bus.program_stop_out); end
    n_cmp++;
    if (seen_q.size() != wrote.size()) begin
      n_bad++; $display("FAIL pend_count: got %0d bytes want %0d", seen_q.size(), wrote.size());
    end else begin
      for (int i = 0; i < wrote.size(); i++)
        if (seen_q[i] !== wrote[i]) begin n_bad++; $display("FAIL pend_byte%0d: got %h want %h", i, seen_q[i], wrote[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] exp_din;
    logic       exp_pop;
    int         op;
    int         pct;
    int         n;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pct = (i < 200) ? 20 : 70;
      bus.tx_ready_in = ($urandom_range(0, 99) < pct);
      bus.rx_valid_in = 1'($urandom_range(0, 1));
      bus.rx_data_in  = 8'($urandom());
      d = 8'($urandom());
      if ($urandom_range(0, 3) == 0) d = 8'h00;
      op = $urandom_range(0, 5);
      exp_din = bus.rx_valid_in ? bus.rx_data_in : 8'h00;
      exp_pop = (op == 3) && bus.rx_valid_in;
      case (op)
        0, 1, 2: cycle(1'b1, io_addr(A_DATA), d);
        3:       cycle(1'b0, io_addr(A_DATA), d);
        4:       cycle(1'b1, nonio_addr(), d);
        default: cycle(1'b1, io_addr(18'h30001 + 18'($urandom_range(0, 2))), d);
      endcase
      n_cmp++; if (bus.tx_valid_out !== (m_fifo.size() != 0)) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %0d", i, bus.tx_valid_out, m_fifo.size()); end
      n_cmp++; if (bus.io_buffer_full !== (m_fifo.size() >= DEPTH - MARGIN)) begin n_bad++; $display("FAIL rnd_full@%0d: got %b size %0d", i, bus.io_buffer_full, m_fifo.size()); end
      n_cmp++; if (bus.tx_overflow_out !== m_overflow) begin n_bad++; $display("FAIL rnd_overflow@%0d: got %b want %b", i, bus.tx_overflow_out, m_overflow); end
      n_cmp++; if (bus.rx_pop_out !== exp_pop) begin n_bad++; $display("FAIL rnd_rx_pop@%0d: got %b want %b", i, bus.rx_pop_out, exp_pop); end
      if (op == 3) begin
        n_cmp++; if (bus.cpu_din_out !== exp_din) begin n_bad++; $display("FAIL rnd_din@%0d: got %h want %h", i, bus.cpu_din_out, exp_din); end
      end
    end
    bus.tx_ready_in = 1'b1;
    idle(DEPTH + 2);
    n = (seen_q.size() < m_tx.size()) ? seen_q.size() : m_tx.size();
    n_cmp++; if (seen_q.size() != m_tx.size()) begin n_bad++; $display("FAIL rnd_count: got %0d bytes want %0d", seen_q.size(), m_tx.size()); end
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (seen_q[i] !== m_tx[i]) begin n_bad++; $display("FAIL rnd_byte%0d: got %h want %h", i, seen_q[i], m_tx[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.tx_ready_in = 1'b0;
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = 8'hA5;
    cycle(1'b0, io_addr(A_DATA), 8'h00);
    bus.rx_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b1, io_addr(A_DATA), 8'($urandom_range(1, 255)));
    n_cmp++; if (bus.tx_valid_out !== 1'b1 || bus.cpu_din_out !== 8'hA5) begin
      n_bad++; $display("FAIL mid_before: got v=%b din=%h want v=1 din=a5", bus.tx_valid_out, bus.cpu_din_out);
    end
    #2 rst_in = 1'b0;
    #1;
    n_cmp++; if (bus.tx_valid_out !== 1'b0) begin n_bad++; $display("FAIL mid_tx_valid: got %b want 0", bus.tx_valid_out); end
    n_cmp++; if (bus.tx_data_out !== 8'h00) begin n_bad++; $display("FAIL mid_tx_data: got %h want 00", bus.tx_data_out); end
    n_cmp++; if (bus.cpu_din_out !== 8'h00) begin n_bad++; $display("FAIL mid_din: got %h want 00", bus.cpu_din_out); end
    n_cmp++; if (bus.io_buffer_full !== 1'b0 || bus.rx_pop_out !== 1'b0 || bus.program_stop_out !== 1'b0 || bus.tx_overflow_out !== 1'b0) begin
      n_bad++; $display("FAIL mid_flags: got full=%b pop=%b stop=%b ovf=%b want all 0", bus.io_buffer_full, bus.rx_pop_out, bus.program_stop_out, bus.tx_overflow_out);
    end
    @(negedge clk_in);
    model_clear();
    rst_in = 1'b1;
    bus.tx_ready_in = 1'b1;
    idle(4);
    n_cmp++; if (seen_q.size() != 0 || bus.tx_valid_out !== 1'b0) begin
      n_bad++; $display("FAIL mid_after: got %0d bytes v=%b want 0 bytes v=0", seen_q.size(), bus.tx_valid_out);
    end
  endtask

  task automatic test_stop();
    logic [7:0] b[3];
    int         budget;
    do_reset();
    bus.tx_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom_range(1, 255));
      cycle(1'b1, io_addr(A_DATA), b[i]);
    end
    cycle(1'b1, io_addr(A_CNT0), 8'($urandom()));
    bus.tx_ready_in = 1'b1;
    budget = 0;
    while (bus.tx_valid_out === 1'b1 && budget < 20) begin
      cycle(1'b1, io_addr(A_DATA), 8'h5A);
      budget++;
    end
    n_cmp++; if (bus.tx_valid_out !== 1'b0) begin n_bad++; $display("FAIL stop_drain_timeout: got v=%b want 0", bus.tx_valid_out); end
    n_cmp++; if (bus.program_stop_out !== 1'b0) begin n_bad++; $display("FAIL stop_early: got %b want 0", bus.program_stop_out); end
    cycle(1'b1, io_addr(A_DATA), 8'h66);
    n_cmp++; if (bus.program_stop_out !== 1'b1) begin n_bad++; $display("FAIL stop_rise: got %b want 1", bus.program_stop_out); end
    for (int i = 0; i < 3; i++) cycle(1'b1, io_addr(A_DATA), 8'h60 + 8'(i));
    n_cmp++; if (bus.tx_valid_out !== 1'b0 || bus.program_stop_out !== 1'b1) begin
      n_bad++; $display("FAIL stop_ignore_wr: got v=%b stop=%b want v=0 stop=1", bus.tx_valid_out, bus.program_stop_out);
    end
    n_cmp++;
    if (seen_q.size() != 4) begin
      n_bad++; $display("FAIL stop_count: got %0d bytes want 4", seen_q.size());
    end else if (seen_q[0] !== b[0] || seen_q[1] !== b[1] || seen_q[2] !== b[2] || seen_q[3] !== 8'h00) begin
      n_bad++; $display("FAIL stop_stream: got %h %h %h %h want %h %h %h 00", seen_q[0], seen_q[1], seen_q[2], seen_q[3], b[0], b[1], b[2]);
    end
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = 8'h3C;
    cycle(1'b0, io_addr(A_DATA), 8'h00);
    n_cmp++; if (bus.cpu_din_out !== 8'h3C || bus.rx_pop_out !== 1'b1) begin
      n_bad++; $display("FAIL stop_read: got d=%h p=%b want d=3c p=1", bus.cpu_din_out, bus.rx_pop_out);
    end
    bus.rx_valid_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in          = 1'b0;
    bus.cpu_wr_in   = 1'b0;
    bus.cpu_a_in    = '0;
    bus.cpu_dout_in = '0;
    bus.tx_ready_in = 1'b0;
    bus.rx_valid_in = 1'b0;
    bus.rx_data_in  = '0;
    model_clear();
    test_reset();
    test_zero_filter();
    test_rx_read();
    test_counter();
    test_backpressure();
    test_stop_pending();
    test_random();
    test_reset_mid();
    test_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
